debounce_multi: RTL and testbench

Parametrised multi-channel debouncer for mechanical inputs such as push-buttons and switches. Each channel has an N-stage input synchroniser and a stability counter. The debounced level changes only after the synchronised input has differed from it for STABLE_CNT consecutive clocks. One-cycle rise and fall strobes are also produced, so counter and FSM logic downstream can consume button presses directly.

---
 rtl/debounce_multi_if.sv | 34 +++
 rtl/debounce_multi.sv | 75 +++++++
 tb/tb_debounce_multi.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// ============================================================================
// Module   : debounce_multi_if
// Brief    : Bundle of raw inputs and debounced levels/strobes for debounce_multi
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] inp;
    logic [CHANNELS-1:0] outp;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                any_edge;

    modport master (
        output inp,
        input  outp,
        input  rise,
        input  fall,
        input  any_edge
    );

    modport slave (
        input  inp,
        output outp,
        output rise,
        output fall,
        output any_edge
    );
endinterface

`default_nettype wire

// File: rtl/debounce_multi.sv
// ============================================================================
// Module   : debounce_multi
// Brief    : Multi-channel input debouncer with synchroniser and edge strobes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_multi #(
    parameter int CHANNELS    = 4,
    parameter int STABLE_CNT  = 50000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    debounce_multi_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
    logic [CNT_W-1:0]       r_cnt  [CHANNELS];
    logic [CHANNELS-1:0]    r_outp;
    logic [CHANNELS-1:0]    r_rise;
    logic [CHANNELS-1:0]    r_fall;
    logic                   r_any_edge;

    logic [CHANNELS-1:0]    w_s;
    logic [CHANNELS-1:0]    w_diff;
    logic [CHANNELS-1:0]    w_accept;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign w_s[i]      = r_sync[i][SYNC_STAGES-1];
        assign w_diff[i]   = w_s[i] ^ r_outp[i];
        assign w_accept[i] = w_diff[i] && (r_cnt[i] == c_cnt_last);

        // Any matching cycle throws away accumulated progress.
        always_ff @(posedge clk) begin
            if (!clr_n) begin
                r_sync[i] <= {SYNC_STAGES{RESET_VALUE}};
                r_cnt[i]  <= '0;
            end else begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], bus.inp[i]};
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_outp     <= {CHANNELS{RESET_VALUE}};
            r_rise     <= '0;
            r_fall     <= '0;
            r_any_edge <= 1'b0;
        end else begin
            r_outp     <= r_outp ^ w_accept;
            r_rise     <= w_accept & w_s;
            r_fall     <= w_accept & ~w_s;
            r_any_edge <= |w_accept;
        end
    end

    assign bus.outp     = r_outp;
    assign bus.rise     = r_rise;
    assign bus.fall     = r_fall;
    assign bus.any_edge = r_any_edge;

endmodule

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// ============================================================================
// Module   : tb_debounce_multi
// Brief    : Randomised self-checking bench for debounce_multi with window model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_multi #(
    parameter int CH = 4,
    parameter int ST = 4,
    parameter int SS = 2,
    parameter bit RV = 1'b0
);

    localparam int MAXE = 4096;

    logic clk;
    logic clr_n;

    debounce_multi_if #(.CHANNELS(CH)) bus ();

    debounce_multi #(
        .CHANNELS    (CH),
        .STABLE_CNT  (ST),
        .CNT_W       (16),
        .SYNC_STAGES (SS),
        .RESET_VALUE (RV)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ec    = 0;

    // History of what was applied before each edge, indexed by edge number.
    logic [CH-1:0] h_inp [MAXE];
    bit            h_rst [MAXE];

    logic [CH-1:0] m_outp;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    logic          m_any;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ec);
        end
    endtask

    // Synchronised level the debouncer sees at edge e: the input applied SS
    // edges earlier, unless a reset flushed the chain in between.
    function automatic logic s_at(input int e, input int ch);
        if (e - SS < 0) return RV;
        for (int j = e - SS; j < e; j++)
            if (h_rst[j]) return RV;
        return h_inp[e-SS][ch];
    endfunction

    // A channel flips at edge e when the last ST seen levels, all after the
    // latest reset, disagree with its current level.
    task automatic model_edge(input int e);
        m_rise = '0;
        m_fall = '0;
        if (h_rst[e]) begin
            m_outp = {CH{RV}};
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                bit acc;
                acc = (e - ST + 1 >= 0);
                for (int j = e - ST + 1; acc && j <= e; j++)
                    if (h_rst[j] || s_at(j, ch) == m_outp[ch]) acc = 0;
                if (acc) begin
                    m_outp[ch] = ~m_outp[ch];
                    m_rise[ch] = m_outp[ch];
                    m_fall[ch] = ~m_outp[ch];
                end
            end
        end
        m_any = |(m_rise | m_fall);
    endtask

    task automatic step(input logic rn, input logic [CH-1:0] v);
        if (ec >= MAXE) begin
            $display("FAIL edge_budget: got %0d expected below %0d", ec, MAXE);
            $fatal(1);
        end
        clr_n   = rn;
        bus.inp = v;
        @(posedge clk);
        h_inp[ec] = v;
        h_rst[ec] = !rn;
        model_edge(ec);
        #1;
        chk("outp",     32'(bus.outp),     32'(m_outp));
        chk("rise",     32'(bus.rise),     32'(m_rise));
        chk("fall",     32'(bus.fall),     32'(m_fall));
        chk("any_edge", 32'(bus.any_edge), 32'(m_any));
        ec++;
    endtask

    logic [CH-1:0] tp;
    logic [CH-1:0] v;

    initial begin
        clr_n   = 1'b0;
        bus.inp = '0;
        m_outp  = {CH{RV}};
        m_rise  = '0;
        m_fall  = '0;
        m_any   = 1'b0;
        tp      = {CH{~RV}};

        // Reset held with inputs active, then release and watch the first accept.
        repeat (3) step(1'b0, tp);
        chk("rst_outp", 32'(bus.outp), 32'({CH{RV}}));
        chk("rst_edge", 32'(bus.any_edge), 32'd0);
        for (int k = 1; k <= SS + ST + 1; k++) begin
            step(1'b1, tp);
            if (k == SS + ST - 1) chk("t1_early", 32'(bus.outp), 32'({CH{RV}}));
            if (k == SS + ST) begin
                chk("t1_outp", 32'(bus.outp), 32'(tp));
                chk("t1_rise", 32'(bus.rise), 32'(RV ? '0 : tp));
                chk("t1_any",  32'(bus.any_edge), 32'd1);
            end
            if (k == SS + ST + 1) chk("t1_once", 32'(bus.any_edge), 32'd0);
        end

        // Glitch shorter than the stability window on channel 0.
        repeat (12) step(1'b1, '0);
        repeat (3)  step(1'b1, CH'(4'b0001));
        repeat (12) step(1'b1, '0);

        // Bounce on channel 1 before settling high.
        v = '0;
        foreach (tp[i]) begin end
        for (int k = 0; k < 5; k++) begin
            v[1] = ~k[0];
            step(1'b1, v);
        end
        repeat (10) step(1'b1, v);

        // Two channels accepted in the same cycle, opposite directions.
        repeat (12) step(1'b1, CH'(4'b0100));
        repeat (12) step(1'b1, CH'(4'b0010));

        // Reset in the middle of a count.
        repeat (12) step(1'b1, '0);
        repeat (3)  step(1'b1, CH'(4'b1000));
        step(1'b0, CH'(4'b1000));
        repeat (10) step(1'b1, CH'(4'b1000));

        // Random phase: slow toggles give accepts, fast toggles give rejects.
        v = '0;
        for (int n = 0; n < 1500; n++) begin
            int pr;
            pr = (n < 750) ? 7 : 2;
            for (int ch = 0; ch < CH; ch++)
                if ($urandom_range(0, pr) == 0) v[ch] = ~v[ch];
            step(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
